// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Per-edge action applied to the IF/ID register.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction memory port, IF/ID outputs, status.
// Handshake: none; stall is level backpressure sampled on every rising clk edge,
// and redirect is a single-cycle request that wins over stall.
interface fetch_if import fetch_pkg::*; ();
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_target;
  logic [PC_W-1:0]    fetch_pc;
  logic [INSTR_W-1:0] fetch_instr;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    id_pc_plus4;
  logic               halted;
  logic               misaligned;
  fetch_state_e       state;

  modport slave (
    input  stall, redirect, redirect_target, fetch_instr,
    output fetch_pc, id_valid, id_instr, id_pc, id_pc_plus4, halted, misaligned, state
  );

  modport master (
    output stall, redirect, redirect_target, fetch_instr,
    input  fetch_pc, id_valid, id_instr, id_pc, id_pc_plus4, halted, misaligned, state
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
  import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  ifid_op_e           op,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    valid    <= 1'b1;
                    instr    <= instr_in;
                    pc       <= pc_in;
                    pc_plus4 <= pc_in + PC_W'(4);
                end
                // A bubble keeps the last pc fields; only valid/instr carry meaning.
                IFID_BUBBLE: begin
                    valid <= 1'b0;
                    instr <= NOP_INSTR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, selects the next PC, runs the RUN/HALT FSM, feeds IF/ID.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned     INSTR_MEM_SIZE = 1024
) (
    input logic   clk,
    input logic   rst_n,
    fetch_if.slave bus
);

    fetch_state_e    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic            misaligned, misaligned_next;
    ifid_op_e        ifid_op;
    logic            oob;

    assign oob = ({2'b00, pc[PC_W-1:2]} >= PC_W'(INSTR_MEM_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            misaligned <= misaligned_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        misaligned_next = misaligned;
        ifid_op         = IFID_HOLD;
        case (state)
            RUN: begin
                // Redirect squashes even a stalled decode slot: it holds a wrong-path word.
                if (bus.redirect) begin
                    pc_next = {bus.redirect_target[PC_W-1:2], 2'b00};
                    ifid_op = IFID_BUBBLE;
                    if (bus.redirect_target[1:0] != 2'b00) misaligned_next = 1'b1;
                end else if (oob) begin
                    state_next = HALT;
                    ifid_op    = bus.stall ? IFID_HOLD : IFID_BUBBLE;
                end else if (!bus.stall) begin
                    pc_next = pc + PC_W'(4);
                    ifid_op = IFID_LOAD;
                end
            end
            HALT: begin
                ifid_op = bus.stall ? IFID_HOLD : IFID_BUBBLE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (ifid_op),
        .instr_in (bus.fetch_instr),
        .pc_in    (pc),
        .valid    (bus.id_valid),
        .instr    (bus.id_instr),
        .pc       (bus.id_pc),
        .pc_plus4 (bus.id_pc_plus4)
    );

    assign bus.fetch_pc   = pc;
    assign bus.halted     = (state == HALT);
    assign bus.misaligned = misaligned;
    assign bus.state      = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized run against a reference model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_if bus_a ();
  fetch_if bus_h ();

  logic [31:0] mem_a [0:1023];
  assign bus_a.fetch_instr = mem_a[bus_a.fetch_pc[11:2]];
  assign bus_h.fetch_instr = (bus_h.fetch_pc >> 2) + 32'd100;

  instruction_fetch_unit #(.RESET_PC(32'h0), .INSTR_MEM_SIZE(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  instruction_fetch_unit #(.RESET_PC(32'h0), .INSTR_MEM_SIZE(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .bus(bus_h.slave));

  // Reference model state for dut_a
  logic [31:0] m_pc, m_instr, m_id_pc, m_plus4;
  logic        m_valid, m_halted, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_id_pc = 32'h0; m_plus4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt);
    if (!m_halted) begin
      if (rd) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_instr = 32'h0;
        if (tgt % 4 != 0) m_mis = 1'b1;
      end else if (m_pc / 4 >= 1024) begin
        m_halted = 1'b1;
        if (!st) begin m_valid = 1'b0; m_instr = 32'h0; end
      end else if (!st) begin
        m_valid = 1'b1; m_instr = mem_a[m_pc / 4]; m_id_pc = m_pc;
        m_plus4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_target = 32'h0;
    bus_h.stall = 1'b0; bus_h.redirect = 1'b0; bus_h.redirect_target = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 1024; k++) mem_a[k] = 32'(k + 100);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    tests_run++; if (bus_a.fetch_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_fetch_pc got=%h exp=0", bus_a.fetch_pc); end
    tests_run++; if (bus_a.id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid got=%b exp=0", bus_a.id_valid); end
    tests_run++; if (bus_a.id_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_id_instr got=%h exp=0", bus_a.id_instr); end
    tests_run++; if (bus_a.id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc got=%h exp=0", bus_a.id_pc); end
    tests_run++; if (bus_a.id_pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc_plus4 got=%h exp=0", bus_a.id_pc_plus4); end
    tests_run++; if (bus_a.halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got=%b exp=0", bus_a.halted); end
    tests_run++; if (bus_a.misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned got=%b exp=0", bus_a.misaligned); end
    tests_run++; if (bus_a.state !== RUN) begin tests_failed++; $display("FAIL reset_state got=%0d exp=RUN", bus_a.state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus_a.id_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus_a.id_valid); end
      tests_run++; if (bus_a.id_pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus_a.id_pc, 4 * i); end
      tests_run++; if (bus_a.id_instr !== 32'(100 + i)) begin tests_failed++; $display("FAIL seq_instr[%0d] got=%0d exp=%0d", i, bus_a.id_instr, 100 + i); end
      tests_run++; if (bus_a.id_pc_plus4 !== 32'(4 * i + 4)) begin tests_failed++; $display("FAIL seq_plus4[%0d] got=%h exp=%h", i, bus_a.id_pc_plus4, 4 * i + 4); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) tick();
    bus_a.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus_a.fetch_pc !== 32'd12) begin tests_failed++; $display("FAIL stall_fetch_pc[%0d] got=%h exp=c", i, bus_a.fetch_pc); end
      tests_run++; if (bus_a.id_pc !== 32'd8 || bus_a.id_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_id_pc[%0d] got=%h/%b exp=8/1", i, bus_a.id_pc, bus_a.id_valid); end
    end
    bus_a.stall = 1'b0;
    tick();
    tests_run++; if (bus_a.id_pc !== 32'd12) begin tests_failed++; $display("FAIL stall_release_pc got=%h exp=c", bus_a.id_pc); end
  endtask

  task automatic test_redirect();
    tests_run++; if (bus_a.fetch_pc !== 32'h10) begin tests_failed++; $display("FAIL redir_pre_pc got=%h exp=10", bus_a.fetch_pc); end
    bus_a.redirect = 1'b1; bus_a.redirect_target = 32'h40; bus_a.stall = 1'b1;
    tick();
    bus_a.redirect = 1'b0; bus_a.stall = 1'b0;
    tests_run++; if (bus_a.id_valid !== 1'b0 || bus_a.id_instr !== 32'h0) begin tests_failed++; $display("FAIL redir_bubble got=%b/%h exp=0/0", bus_a.id_valid, bus_a.id_instr); end
    tests_run++; if (bus_a.fetch_pc !== 32'h40) begin tests_failed++; $display("FAIL redir_fetch_pc got=%h exp=40", bus_a.fetch_pc); end
    tick();
    tests_run++; if (bus_a.id_valid !== 1'b1 || bus_a.id_pc !== 32'h40) begin tests_failed++; $display("FAIL redir_target got=%b/%h exp=1/40", bus_a.id_valid, bus_a.id_pc); end
    tests_run++; if (bus_a.id_instr !== 32'd116) begin tests_failed++; $display("FAIL redir_instr got=%0d exp=116", bus_a.id_instr); end
  endtask

  task automatic test_misaligned();
    bus_a.redirect = 1'b1; bus_a.redirect_target = 32'h23;
    tick();
    tests_run++; if (bus_a.fetch_pc !== 32'h20) begin tests_failed++; $display("FAIL mis_fetch_pc got=%h exp=20", bus_a.fetch_pc); end
    tests_run++; if (bus_a.misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_set got=%b exp=1", bus_a.misaligned); end
    bus_a.redirect_target = 32'h44;
    tick();
    bus_a.redirect = 1'b0;
    repeat (2) tick();
    tests_run++; if (bus_a.misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky got=%b exp=1", bus_a.misaligned); end
    tests_run++; if (bus_a.id_pc !== 32'h48) begin tests_failed++; $display("FAIL mis_after_pc got=%h exp=48", bus_a.id_pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus_h.id_valid !== 1'b1 || bus_h.id_pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL halt_seq[%0d] got=%b/%h exp=1/%h", i, bus_h.id_valid, bus_h.id_pc, 4 * i); end
    end
    tests_run++; if (bus_h.halted !== 1'b0) begin tests_failed++; $display("FAIL halt_early got=%b exp=0", bus_h.halted); end
    tick();
    tests_run++; if (bus_h.halted !== 1'b1 || bus_h.state !== HALT) begin tests_failed++; $display("FAIL halt_set got=%b exp=1", bus_h.halted); end
    tests_run++; if (bus_h.id_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_bubble got=%b exp=0", bus_h.id_valid); end
    tests_run++; if (bus_h.fetch_pc !== 32'd16) begin tests_failed++; $display("FAIL halt_fetch_pc got=%h exp=10", bus_h.fetch_pc); end
    bus_h.redirect = 1'b1; bus_h.redirect_target = 32'h0;
    repeat (2) tick();
    bus_h.redirect = 1'b0;
    tests_run++; if (bus_h.fetch_pc !== 32'd16 || bus_h.halted !== 1'b1 || bus_h.id_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_redirect_ignored got pc=%h h=%b v=%b exp=10/1/0", bus_h.fetch_pc, bus_h.halted, bus_h.id_valid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (4) tick();
    bus_h.stall = 1'b1;
    tick();
    tests_run++; if (bus_h.halted !== 1'b1 || bus_h.id_valid !== 1'b1 || bus_h.id_pc !== 32'd12) begin tests_failed++; $display("FAIL areset_pre got h=%b v=%b pc=%h exp=1/1/c", bus_h.halted, bus_h.id_valid, bus_h.id_pc); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus_h.halted !== 1'b0 || bus_h.state !== RUN) begin tests_failed++; $display("FAIL areset_halted got=%b exp=0", bus_h.halted); end
    tests_run++; if (bus_h.id_valid !== 1'b0 || bus_h.id_instr !== 32'h0) begin tests_failed++; $display("FAIL areset_ifid got=%b/%h exp=0/0", bus_h.id_valid, bus_h.id_instr); end
    tests_run++; if (bus_h.id_pc !== 32'h0 || bus_h.id_pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL areset_idpc got=%h/%h exp=0/0", bus_h.id_pc, bus_h.id_pc_plus4); end
    tests_run++; if (bus_h.fetch_pc !== 32'h0) begin tests_failed++; $display("FAIL areset_fetch_pc got=%h exp=0", bus_h.fetch_pc); end
    bus_h.stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++; if (bus_h.id_valid !== 1'b1 || bus_h.id_pc !== 32'h0 || bus_h.id_instr !== 32'd100) begin tests_failed++; $display("FAIL areset_restart got=%b/%h/%0d exp=1/0/100", bus_h.id_valid, bus_h.id_pc, bus_h.id_instr); end
    tests_run++; if (bus_h.fetch_pc !== 32'd4) begin tests_failed++; $display("FAIL areset_restart_pc got=%h exp=4", bus_h.fetch_pc); end
  endtask

  task automatic test_random();
    logic st, rd;
    logic [31:0] tgt;
    for (int k = 0; k < 1024; k++) mem_a[k] = $urandom;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      model_reset();
      for (int c = 0; c < 150; c++) begin
        st  = ($urandom_range(0, 3) == 0);
        rd  = ($urandom_range(0, 9) == 0);
        tgt = $urandom_range(0, 4300);
        if (c == 140 && r == 3) begin rd = 1'b1; tgt = 32'd4092; end
        bus_a.stall = st; bus_a.redirect = rd; bus_a.redirect_target = tgt;
        model_step(st, rd, tgt);
        tick();
        tests_run++; if (bus_a.fetch_pc !== m_pc) begin tests_failed++; $display("FAIL rnd_fetch_pc[%0d.%0d] got=%h exp=%h", r, c, bus_a.fetch_pc, m_pc); end
        tests_run++; if (bus_a.id_valid !== m_valid || bus_a.id_instr !== m_instr) begin tests_failed++; $display("FAIL rnd_ifid[%0d.%0d] got=%b/%h exp=%b/%h", r, c, bus_a.id_valid, bus_a.id_instr, m_valid, m_instr); end
        if (m_valid) begin
          tests_run++; if (bus_a.id_pc !== m_id_pc || bus_a.id_pc_plus4 !== m_plus4) begin tests_failed++; $display("FAIL rnd_idpc[%0d.%0d] got=%h/%h exp=%h/%h", r, c, bus_a.id_pc, bus_a.id_pc_plus4, m_id_pc, m_plus4); end
        end
        tests_run++; if (bus_a.halted !== m_halted || bus_a.misaligned !== m_mis) begin tests_failed++; $display("FAIL rnd_status[%0d.%0d] got=%b/%b exp=%b/%b", r, c, bus_a.halted, bus_a.misaligned, m_halted, m_mis); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
